// File: rtl/sprite_addr_cal.sv
// sprite_addr_cal: per-pixel sprite hit test and pattern-memory address generator.
// Stage 1 resolves the hit test and the region offsets. Stage 2 tiles the offsets
// into the source pattern, applies the mirror and forms the address.
// The result appears on the outputs two clocks after the inputs are sampled.
module sprite_addr_cal #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned COORD_W = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5*ADDR_W-1:0]    pattern_info,
  input  logic [3*COORD_W+1:0]   sprite_info,
  input  logic [COORD_W-1:0]     hcount,
  input  logic [COORD_W-1:0]     vcount,
  output logic [ADDR_W-1:0]      addr_output,
  output logic                   valid
);

  // ex needs one extra bit so that hcount + shift never wraps.
  localparam int unsigned EXW  = COORD_W + 1;
  // Every hit-test comparison is done unsigned at this width.
  localparam int unsigned CMPW = ADDR_W + 1;

  // Remainder by restoring long division: one compare-subtract per dividend bit.
  // The loop has a fixed trip count, so any quotient that EXW bits allow is covered.
  function automatic logic [ADDR_W-1:0] mod_sub(input logic [EXW-1:0] n,
                                                input logic [ADDR_W-1:0] d);
    logic [ADDR_W:0] r;
    r = '0;
    for (int unsigned i = 0; i < EXW; i++) begin
      r = {r[ADDR_W-1:0], n[EXW-1-i]};
      if (r >= {1'b0, d}) r = r - {1'b0, d};
    end
    return r[ADDR_W-1:0];
  endfunction

  // Descriptor and sprite fields
  logic [ADDR_W-1:0]  w_base, w_src_w, w_src_h, w_draw_w, w_draw_h;
  logic               w_visible, w_flip;
  logic [COORD_W-1:0] w_x, w_y, w_shift;

  assign w_base    = pattern_info[5*ADDR_W-1 -: ADDR_W];
  assign w_src_w   = pattern_info[4*ADDR_W-1 -: ADDR_W];
  assign w_src_h   = pattern_info[3*ADDR_W-1 -: ADDR_W];
  assign w_draw_w  = pattern_info[2*ADDR_W-1 -: ADDR_W];
  assign w_draw_h  = pattern_info[ADDR_W-1:0];
  assign w_visible = sprite_info[3*COORD_W+1];
  assign w_flip    = sprite_info[3*COORD_W];
  assign w_x       = sprite_info[3*COORD_W-1 -: COORD_W];
  assign w_y       = sprite_info[2*COORD_W-1 -: COORD_W];
  assign w_shift   = sprite_info[COORD_W-1:0];

  // Stage 1 combinational: effective column, offsets, hit test
  logic [EXW-1:0]     w_ex, w_dx;
  logic [COORD_W-1:0] w_dy;
  logic               w_degenerate, w_hit;

  assign w_ex = {1'b0, hcount} + {1'b0, w_shift};
  assign w_dx = w_ex - {1'b0, w_x};
  assign w_dy = vcount - w_y;

  assign w_degenerate = (w_src_w == '0) | (w_src_h == '0) |
                        (w_draw_w == '0) | (w_draw_h == '0);

  // The offsets wrap when the pixel lies left of or above the sprite. The
  // ">= x" and ">= y" terms reject those pixels before the offsets are used.
  assign w_hit = w_visible & ~w_degenerate &
                 (CMPW'(w_ex)   >= CMPW'(w_x)) &
                 (CMPW'(w_dx)   <  CMPW'(w_draw_w)) &
                 (CMPW'(vcount) >= CMPW'(w_y)) &
                 (CMPW'(w_dy)   <  CMPW'(w_draw_h));

  // Stage 1 registers
  logic               r1_hit, r1_flip;
  logic [EXW-1:0]     r1_dx;
  logic [COORD_W-1:0] r1_dy;
  logic [ADDR_W-1:0]  r1_base, r1_src_w, r1_src_h;

  // Capture the hit flag, the offsets and the descriptor fields that stage 2 needs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r1_hit   <= 1'b0;
      r1_flip  <= 1'b0;
      r1_dx    <= '0;
      r1_dy    <= '0;
      r1_base  <= '0;
      r1_src_w <= '0;
      r1_src_h <= '0;
    end else begin
      r1_hit   <= w_hit;
      r1_flip  <= w_flip;
      r1_dx    <= w_dx;
      r1_dy    <= w_dy;
      r1_base  <= w_base;
      r1_src_w <= w_src_w;
      r1_src_h <= w_src_h;
    end
  end

  // Stage 2 combinational: tiling, horizontal mirror, address
  logic [ADDR_W-1:0] w_sx, w_sy, w_sxp, w_row, w_addr;

  assign w_sx   = mod_sub(r1_dx, r1_src_w);
  assign w_sy   = mod_sub({1'b0, r1_dy}, r1_src_h);
  assign w_sxp  = r1_flip ? (r1_src_w - ADDR_W'(1) - w_sx) : w_sx;
  assign w_row  = w_sy * r1_src_w;
  assign w_addr = r1_base + w_row + w_sxp;

  // Output registers. The address is forced to zero on a miss so it is never stale.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid       <= 1'b0;
      addr_output <= '0;
    end else begin
      valid       <= r1_hit;
      addr_output <= r1_hit ? w_addr : '0;
    end
  end

endmodule

// File: tb/tb_sprite_addr_cal.sv
// Scoreboard bench for sprite_addr_cal: directed vectors with hand-computed results.
// The stimulus process queues the expected output for each applied vector. The monitor
// pops and compares the queued entry when that vector's result reaches the outputs.
module tb_sprite_addr_cal;

  logic        clk = 1'b0;
  logic        reset;
  logic [79:0] pattern_info;
  logic [31:0] sprite_info;
  logic [9:0]  hcount, vcount;
  logic [15:0] addr_output;
  logic        valid;

  sprite_addr_cal #(.ADDR_W(16), .COORD_W(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .pattern_info (pattern_info),
    .sprite_info  (sprite_info),
    .hcount       (hcount),
    .vcount       (vcount),
    .addr_output  (addr_output),
    .valid        (valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] a;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic issue;
  logic p1, p2;

  // Track which output cycles carry a result for a queued vector (two-clock latency).
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      p1 <= 1'b0;
      p2 <= 1'b0;
    end else begin
      p1 <= issue;
      p2 <= p1;
    end
  end

  // Monitor: compare the presented output against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && p2) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: got valid=%0b addr=%0d, no expected entry", valid, addr_output);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (valid !== e.v || addr_output !== e.a) begin
          errors++;
          $display("FAIL %s: got valid=%0b addr=%0d, expected valid=%0b addr=%0d",
                   e.name, valid, addr_output, e.v, e.a);
        end
      end
    end
  end

  function automatic logic [79:0] pat(input logic [15:0] b, sw, sh, dw, dh);
    return {b, sw, sh, dw, dh};
  endfunction

  function automatic logic [31:0] spr(input logic vis, input logic fl,
                                     input logic [9:0] x, input logic [9:0] y,
                                     input logic [9:0] sh);
    return {vis, fl, x, y, sh};
  endfunction

  task automatic apply(input logic [79:0] p, input logic [31:0] s,
                       input logic [9:0] h, input logic [9:0] v,
                       input logic ev, input logic [15:0] ea, input string name);
    exp_t e;
    @(negedge clk);
    pattern_info = p;
    sprite_info  = s;
    hcount       = h;
    vcount       = v;
    issue        = 1'b1;
    e.v = ev;
    e.a = ea;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic chk_now(input string name, input logic gv, input logic [15:0] ga,
                         input logic ev, input logic [15:0] ea);
    checks++;
    if (gv !== ev || ga !== ea) begin
      errors++;
      $display("FAIL %s: got valid=%0b addr=%0d, expected valid=%0b addr=%0d",
               name, gv, ga, ev, ea);
    end
  endtask

  logic [79:0] P0, P4;

  initial begin
    P0 = pat(16'd0, 16'd32, 16'd24, 16'd32, 16'd24);
    P4 = pat(16'd544, 16'd32, 16'd1, 16'd32, 16'd128);
    reset = 1'b1;
    issue = 1'b0;
    pattern_info = '0;
    sprite_info  = '0;
    hcount = '0;
    vcount = '0;
    #2;
    chk_now("reset_state", valid, addr_output, 1'b0, 16'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Basic region, corners and just-outside pixels
    apply(P0, spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd0), 10'd100, 10'd50, 1'b1, 16'd0,   "origin");
    apply(P0, spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd0), 10'd131, 10'd73, 1'b1, 16'd767, "last_corner");
    apply(P0, spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd0), 10'd132, 10'd73, 1'b0, 16'd0,   "dx_eq_draw_w");
    apply(P0, spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd0), 10'd99,  10'd50, 1'b0, 16'd0,   "left_of_x");
    apply(P0, spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd0), 10'd100, 10'd49, 1'b0, 16'd0,   "above_y");
    apply(P0, spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd0), 10'd100, 10'd74, 1'b0, 16'd0,   "dy_eq_draw_h");
    // Horizontal mirror
    apply(P0, spr(1'b1, 1'b1, 10'd100, 10'd50, 10'd0), 10'd100, 10'd50, 1'b1, 16'd31,  "flip_origin");
    apply(P0, spr(1'b1, 1'b1, 10'd100, 10'd50, 10'd0), 10'd131, 10'd51, 1'b1, 16'd32,  "flip_row1");
    // Vertical tiling with a one-row pattern
    apply(P4, spr(1'b1, 1'b0, 10'd0, 10'd0, 10'd0), 10'd5,  10'd100, 1'b1, 16'd549, "tile_v_a");
    apply(P4, spr(1'b1, 1'b0, 10'd0, 10'd0, 10'd0), 10'd31, 10'd127, 1'b1, 16'd575, "tile_v_b");
    apply(P4, spr(1'b1, 1'b0, 10'd0, 10'd0, 10'd0), 10'd5,  10'd128, 1'b0, 16'd0,   "tile_v_out");
    // Horizontal tiling: 8-wide pattern drawn 32 wide, dx=10 -> sx=2
    apply(pat(16'd0, 16'd8, 16'd24, 16'd32, 16'd24), spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd0),
          10'd110, 10'd50, 1'b1, 16'd2, "tile_h");
    apply(pat(16'd0, 16'd8, 16'd24, 16'd32, 16'd24), spr(1'b1, 1'b1, 10'd100, 10'd50, 10'd0),
          10'd110, 10'd50, 1'b1, 16'd5, "tile_h_flip");
    // Shift and visibility
    apply(P0, spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd4), 10'd96,  10'd50, 1'b1, 16'd0, "shift_hit");
    apply(P0, spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd4), 10'd95,  10'd50, 1'b0, 16'd0, "shift_miss");
    apply(P0, spr(1'b0, 1'b0, 10'd100, 10'd50, 10'd0), 10'd110, 10'd60, 1'b0, 16'd0, "invisible");
    // Degenerate descriptors
    apply(pat(16'd0, 16'd0, 16'd24, 16'd32, 16'd24), spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd0),
          10'd100, 10'd50, 1'b0, 16'd0, "src_w_zero");
    apply(pat(16'd0, 16'd32, 16'd24, 16'd32, 16'd0), spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd0),
          10'd100, 10'd50, 1'b0, 16'd0, "draw_h_zero");
    // Address wraps mod 2^16: 0xFFF0 + 31 -> 15
    apply(pat(16'hFFF0, 16'd32, 16'd24, 16'd32, 16'd24), spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd0),
          10'd131, 10'd50, 1'b1, 16'd15, "addr_wrap");
    // ex = 1023 + 1023 = 2046 must not wrap: dx = 1023
    apply(pat(16'd0, 16'd1024, 16'd24, 16'd2048, 16'd24), spr(1'b1, 1'b0, 10'd1023, 10'd50, 10'd1023),
          10'd1023, 10'd50, 1'b1, 16'd1023, "ex_no_wrap");

    // Reset while valid=1: outputs clear at once, then results resume
    apply(P0, spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd0), 10'd110, 10'd50, 1'b1, 16'd10, "pre_reset");
    @(negedge clk);
    issue = 1'b0;
    @(negedge clk);
    #2;
    chk_now("valid_before_reset", valid, addr_output, 1'b1, 16'd10);
    reset = 1'b1;
    #1;
    chk_now("async_reset", valid, addr_output, 1'b0, 16'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    apply(P0, spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd0), 10'd131, 10'd73, 1'b1, 16'd767, "post_reset");

    // Sweep one column per clock across the sprite at vcount=60 (dy=10, row base 320)
    for (int h = 90; h <= 140; h++) begin
      logic ev;
      ev = (h >= 100 && h <= 131);
      apply(P0, spr(1'b1, 1'b0, 10'd100, 10'd50, 10'd0), 10'(h), 10'd60, ev,
            ev ? 16'(320 + h - 100) : 16'd0, $sformatf("sweep_h%0d", h));
    end
    @(negedge clk);
    issue = 1'b0;

    // Drain with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
